// File: rtl/io_uart_responder_pkg.sv
// Shared constants, FSM state encodings and read-word packing for the CPU IO UART responder.
package io_uart_responder_pkg;

  localparam int WORD        = 32;
  localparam int OVERRUN_BIT = 8;
  localparam int FERR_BIT    = 9;

  typedef enum logic [1:0] {TX_IDLE, TX_START, TX_DATA, TX_STOP} tx_state_e;
  typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_e;

  // Read word seen by the CPU: byte in [7:0], error flags just above it.
  function automatic logic [WORD-1:0] pack_read_word(input logic [7:0] rx_byte,
                                                     input logic       overrun,
                                                     input logic       frame_err);
    logic [WORD-1:0] w;
    w              = '0;
    w[7:0]         = rx_byte;
    w[OVERRUN_BIT] = overrun;
    w[FERR_BIT]    = frame_err;
    return w;
  endfunction

endpackage

// File: rtl/io_uart_responder_if.sv
// CPU memory-stage IO handshake between the CPU (master) and the UART responder (slave).
interface io_uart_responder_if;
  import io_uart_responder_pkg::*;

  // Handshake: start is a one-cycle write strobe, accepted only while busy=0
  // (otherwise dropped); ready stays high with data_to_t valid until the CPU
  // pulses clear, which consumes the byte and its error flags.
  logic            start;
  logic            clear;
  logic [WORD-1:0] t_data;
  logic            busy;
  logic            ready;
  logic [WORD-1:0] data_to_t;

  modport master (output start, clear, t_data, input busy, ready, data_to_t);
  modport slave  (input start, clear, t_data, output busy, ready, data_to_t);

endinterface

// File: rtl/io_uart_responder_rx_core.sv
// UART receiver: 2-flop synchronizer, mid-bit sampling FSM, registered byte with done/stop_ok.
module io_uart_responder_rx_core
  import io_uart_responder_pkg::*;
#(
  parameter int CLKS_PER_BIT = 868
) (
  input  logic      clk,
  input  logic      rst,
  input  logic      rx_serial,
  output logic      done,
  output logic      stop_ok,
  output logic [7:0] rx_byte,
  output rx_state_e rx_state_dbg
);

  localparam int              CNT_W    = $clog2(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0] BIT_LAST = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] HALF     = CNT_W'(CLKS_PER_BIT / 2 - 1);

  logic             sync1, sync2, sync3;
  rx_state_e        state, state_n;
  logic [CNT_W-1:0] cnt, cnt_n;
  logic [2:0]       bit_idx, bit_idx_n;
  logic [7:0]       shift, shift_n;
  logic             done_n;

  // sync3 is only the previous sync2 value, used for falling-edge detection.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync1 <= 1'b1;
      sync2 <= 1'b1;
      sync3 <= 1'b1;
    end else begin
      sync1 <= rx_serial;
      sync2 <= sync1;
      sync3 <= sync2;
    end
  end

  always_comb begin
    state_n   = state;
    cnt_n     = cnt + CNT_W'(1);
    bit_idx_n = bit_idx;
    shift_n   = shift;
    done_n    = 1'b0;
    case (state)
      RX_IDLE: begin
        cnt_n = '0;
        if (sync3 && !sync2) state_n = RX_START;
      end
      RX_START: begin
        if (cnt == HALF) begin
          cnt_n     = '0;
          bit_idx_n = '0;
          state_n   = sync2 ? RX_IDLE : RX_DATA;
        end
      end
      RX_DATA: begin
        if (cnt == BIT_LAST) begin
          cnt_n     = '0;
          shift_n   = {sync2, shift[7:1]};
          bit_idx_n = bit_idx + 3'd1;
          if (bit_idx == 3'd7) state_n = RX_STOP;
        end
      end
      RX_STOP: begin
        if (cnt == BIT_LAST) begin
          cnt_n   = '0;
          done_n  = 1'b1;
          state_n = RX_IDLE;
        end
      end
      default: state_n = RX_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= RX_IDLE;
      cnt     <= '0;
      bit_idx <= '0;
      shift   <= '0;
      done    <= 1'b0;
      stop_ok <= 1'b0;
      rx_byte <= '0;
    end else begin
      state   <= state_n;
      cnt     <= cnt_n;
      bit_idx <= bit_idx_n;
      shift   <= shift_n;
      done    <= done_n;
      if (done_n) begin
        rx_byte <= shift;
        stop_ok <= sync2;
      end
    end
  end

  assign rx_state_dbg = state;

endmodule

// File: rtl/io_uart_responder.sv
// CPU IO responder: CPU writes become UART TX frames, received UART bytes become a ready flag and read word.
module io_uart_responder
  import io_uart_responder_pkg::*;
#(
  parameter int CLKS_PER_BIT = 868
) (
  input  logic                clk,
  input  logic                rst,
  io_uart_responder_if.slave  cpu,
  input  logic                uart_rx,
  output logic                uart_tx,
  output tx_state_e           tx_state_dbg,
  output rx_state_e           rx_state_dbg
);

  localparam int              CNT_W    = $clog2(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0] BIT_LAST = CNT_W'(CLKS_PER_BIT - 1);

  tx_state_e        tx_state, tx_state_n;
  logic [CNT_W-1:0] tx_cnt, tx_cnt_n;
  logic [2:0]       tx_bit, tx_bit_n;
  logic [7:0]       tx_shift, tx_shift_n;
  logic             tx_line_n;
  logic             busy_q;

  logic             unused_t_data;
  assign unused_t_data = ^cpu.t_data[WORD-1:8];

  always_comb begin
    tx_state_n = tx_state;
    tx_cnt_n   = tx_cnt + CNT_W'(1);
    tx_bit_n   = tx_bit;
    tx_shift_n = tx_shift;
    case (tx_state)
      TX_IDLE: begin
        tx_cnt_n = '0;
        if (cpu.start) begin
          tx_shift_n = cpu.t_data[7:0];
          tx_state_n = TX_START;
        end
      end
      TX_START: begin
        if (tx_cnt == BIT_LAST) begin
          tx_cnt_n   = '0;
          tx_bit_n   = '0;
          tx_state_n = TX_DATA;
        end
      end
      TX_DATA: begin
        if (tx_cnt == BIT_LAST) begin
          tx_cnt_n   = '0;
          tx_shift_n = {1'b0, tx_shift[7:1]};
          tx_bit_n   = tx_bit + 3'd1;
          if (tx_bit == 3'd7) tx_state_n = TX_STOP;
        end
      end
      TX_STOP: begin
        if (tx_cnt == BIT_LAST) begin
          tx_cnt_n   = '0;
          tx_state_n = TX_IDLE;
        end
      end
      default: tx_state_n = TX_IDLE;
    endcase

    // Line level is computed from the next state so the register lines up with it.
    case (tx_state_n)
      TX_START: tx_line_n = 1'b0;
      TX_DATA:  tx_line_n = tx_shift_n[0];
      default:  tx_line_n = 1'b1;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      tx_state <= TX_IDLE;
      tx_cnt   <= '0;
      tx_bit   <= '0;
      tx_shift <= '0;
      uart_tx  <= 1'b1;
      busy_q   <= 1'b0;
    end else begin
      tx_state <= tx_state_n;
      tx_cnt   <= tx_cnt_n;
      tx_bit   <= tx_bit_n;
      tx_shift <= tx_shift_n;
      uart_tx  <= tx_line_n;
      busy_q   <= (tx_state_n != TX_IDLE);
    end
  end

  assign cpu.busy     = busy_q;
  assign tx_state_dbg = tx_state;

  logic       rx_done;
  logic       rx_stop_ok;
  logic [7:0] rx_byte;

  io_uart_responder_rx_core #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_rx (
    .clk          (clk),
    .rst          (rst),
    .rx_serial    (uart_rx),
    .done         (rx_done),
    .stop_ok      (rx_stop_ok),
    .rx_byte      (rx_byte),
    .rx_state_dbg (rx_state_dbg)
  );

  logic       ready_q;
  logic       overrun_q;
  logic       frame_err_q;
  logic [7:0] byte_q;

  // A completion on the same edge as clear wins; clear only wipes the old flags first.
  always_ff @(posedge clk) begin
    if (rst) begin
      ready_q     <= 1'b0;
      overrun_q   <= 1'b0;
      frame_err_q <= 1'b0;
      byte_q      <= '0;
    end else if (rx_done) begin
      ready_q     <= 1'b1;
      byte_q      <= rx_byte;
      overrun_q   <= (cpu.clear ? 1'b0 : overrun_q) | (ready_q & ~cpu.clear);
      frame_err_q <= (cpu.clear ? 1'b0 : frame_err_q) | ~rx_stop_ok;
    end else if (cpu.clear) begin
      ready_q     <= 1'b0;
      overrun_q   <= 1'b0;
      frame_err_q <= 1'b0;
    end
  end

  assign cpu.ready     = ready_q;
  assign cpu.data_to_t = pack_read_word(byte_q, overrun_q, frame_err_q);

endmodule

// File: tb/tb_io_uart_responder.sv
// Directed plus randomized bench for io_uart_responder at CLKS_PER_BIT=4.
module tb_io_uart_responder;
  import io_uart_responder_pkg::*;

  localparam int CPB    = 4;
  localparam int RX_LEN = 10 * CPB + 8;

  logic      clk;
  logic      rst;
  logic      uart_rx;
  logic      uart_tx;
  tx_state_e tx_state_dbg;
  rx_state_e rx_state_dbg;

  io_uart_responder_if cpu_if ();

  io_uart_responder #(.CLKS_PER_BIT(CPB)) dut (
    .clk          (clk),
    .rst          (rst),
    .cpu          (cpu_if.slave),
    .uart_rx      (uart_rx),
    .uart_tx      (uart_tx),
    .tx_state_dbg (tx_state_dbg),
    .rx_state_dbg (rx_state_dbg)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // reference model of the CPU-visible RX state
  logic       m_ready, m_ovr, m_ferr;
  logic [7:0] m_byte;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] model_word();
    return {22'b0, m_ferr, m_ovr, m_byte};
  endfunction

  task automatic model_reset();
    m_ready = 1'b0; m_ovr = 1'b0; m_ferr = 1'b0; m_byte = 8'h00;
  endtask

  task automatic model_complete(input logic [7:0] b, input logic stop_good, input logic clr);
    if (clr) begin
      m_ovr  = 1'b0;
      m_ferr = 1'b0;
    end else if (m_ready) begin
      m_ovr = 1'b1;
    end
    if (!stop_good) m_ferr = 1'b1;
    m_ready = 1'b1;
    m_byte  = b;
  endtask

  task automatic check_rx(input string tag);
    check({tag, "_ready"}, {31'b0, cpu_if.ready}, {31'b0, m_ready});
    if (m_ready) check({tag, "_word"}, cpu_if.data_to_t, model_word());
    else         check({tag, "_flags"}, {30'b0, cpu_if.data_to_t[9:8]}, 32'h0);
  endtask

  task automatic pulse_clear();
    cpu_if.clear = 1'b1;
    step();
    cpu_if.clear = 1'b0;
    m_ready = 1'b0; m_ovr = 1'b0; m_ferr = 1'b0;
  endtask

  // Drives one frame on uart_rx; clear is high only in iteration clear_at.
  // rise_at reports the first iteration after which ready was seen high.
  task automatic send_rx(input logic [7:0] b, input logic stop_bit, input int clear_at,
                         output int rise_at);
    logic [9:0] fr;
    fr      = {stop_bit, b, 1'b0};
    rise_at = -1;
    for (int c = 0; c < RX_LEN; c++) begin
      uart_rx      = (c < 10 * CPB) ? fr[c / CPB] : 1'b1;
      cpu_if.clear = (c == clear_at);
      step();
      if (rise_at < 0 && cpu_if.ready) rise_at = c;
    end
    cpu_if.clear = 1'b0;
    uart_rx      = 1'b1;
  endtask

  // Sends one byte and checks busy and the line every cycle; optionally retries start mid-frame.
  task automatic send_tx(input logic [7:0] b, input int ignore_at, input logic [7:0] ignore_b);
    logic [9:0] fr;
    fr            = {1'b1, b, 1'b0};
    cpu_if.t_data = {24'b0, b};
    cpu_if.start  = 1'b1;
    step();
    cpu_if.start  = 1'b0;
    for (int s = 0; s < 44; s++) begin
      check("tx_busy", {31'b0, cpu_if.busy}, {31'b0, (s < 10 * CPB)});
      check("tx_line", {31'b0, uart_tx}, {31'b0, (s < 10 * CPB) ? fr[s / CPB] : 1'b1});
      cpu_if.start = (s == ignore_at);
      if (s == ignore_at) cpu_if.t_data = {24'b0, ignore_b};
      step();
    end
    cpu_if.start = 1'b0;
  endtask

  initial begin
    int         rise11;
    int         r;
    logic [7:0] b;
    logic       good;
    logic [9:0] fr;

    rst           = 1'b1;
    uart_rx       = 1'b1;
    cpu_if.start  = 1'b0;
    cpu_if.clear  = 1'b0;
    cpu_if.t_data = '0;
    model_reset();
    repeat (3) step();
    check("rst_busy",  {31'b0, cpu_if.busy}, 32'h0);
    check("rst_ready", {31'b0, cpu_if.ready}, 32'h0);
    check("rst_word",  cpu_if.data_to_t, 32'h0);
    check("rst_tx",    {31'b0, uart_tx}, 32'h1);
    rst = 1'b0;
    step();

    // TX basic and start-while-busy
    send_tx(8'hA5, -1, 8'h00);
    send_tx(8'hA5, 10, 8'h3C);
    for (int i = 0; i < 8; i++) begin
      check("tx_no_second_frame", {30'b0, cpu_if.busy, uart_tx}, 32'h1);
      step();
    end

    // RX basic
    send_rx(8'h5A, 1'b1, -1, r);
    model_complete(8'h5A, 1'b1, 1'b0);
    check_rx("rx_5a");
    check("rx_5a_const", cpu_if.data_to_t, 32'h0000_005A);
    pulse_clear();
    check_rx("rx_5a_cleared");

    // overrun
    send_rx(8'h11, 1'b1, -1, rise11);
    model_complete(8'h11, 1'b1, 1'b0);
    check_rx("rx_11");
    send_rx(8'h22, 1'b1, -1, r);
    model_complete(8'h22, 1'b1, 1'b0);
    check_rx("rx_22_overrun");
    check("rx_22_const", cpu_if.data_to_t, 32'h0000_0122);

    // clear on the completion edge of 0x33
    check("rx_latency_found", {31'b0, (rise11 >= 0)}, 32'h1);
    send_rx(8'h33, 1'b1, rise11, r);
    model_complete(8'h33, 1'b1, 1'b1);
    check_rx("rx_33_collision");
    check("rx_33_const", cpu_if.data_to_t, 32'h0000_0033);
    pulse_clear();

    // glitch on idle line
    uart_rx = 1'b0;
    step();
    uart_rx = 1'b1;
    repeat (12) step();
    check_rx("rx_glitch");

    // framing error
    send_rx(8'h7E, 1'b0, -1, r);
    model_complete(8'h7E, 1'b0, 1'b0);
    check_rx("rx_7e_ferr");
    check("rx_7e_const", cpu_if.data_to_t, 32'h0000_027E);
    pulse_clear();
    check_rx("rx_7e_cleared");

    // reset during TX data bit 3 and RX data bit 5
    fr = {1'b1, 8'h81, 1'b0};
    for (int c = 0; c <= 26; c++) begin
      uart_rx       = fr[c / CPB];
      cpu_if.start  = (c == 8);
      cpu_if.t_data = 32'h0000_005C;
      step();
    end
    cpu_if.start = 1'b0;
    rst          = 1'b1;
    uart_rx      = 1'b1;
    step();
    rst = 1'b0;
    model_reset();
    check("midrst_tx",    {31'b0, uart_tx}, 32'h1);
    check("midrst_busy",  {31'b0, cpu_if.busy}, 32'h0);
    check("midrst_ready", {31'b0, cpu_if.ready}, 32'h0);
    check("midrst_word",  cpu_if.data_to_t, 32'h0);
    repeat (4) step();
    check("midrst_idle_tx", {31'b0, uart_tx}, 32'h1);
    send_rx(8'h81, 1'b1, -1, r);
    model_complete(8'h81, 1'b1, 1'b0);
    check_rx("rx_81_after_rst");
    check("rx_81_const", cpu_if.data_to_t, 32'h0000_0081);

    // randomized TX bytes
    for (int i = 0; i < 6; i++) begin
      b = 8'($urandom_range(0, 255));
      send_tx(b, -1, 8'h00);
    end

    // randomized RX bytes with random clears and bad stop bits
    for (int i = 0; i < 10; i++) begin
      if ($urandom_range(0, 1) == 1) pulse_clear();
      b    = 8'($urandom_range(0, 255));
      good = ($urandom_range(0, 3) != 0);
      send_rx(b, good, -1, r);
      model_complete(b, good, 1'b0);
      check_rx("rx_rand");
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
